// File: rtl/seq_rep_monitor_if.sv
// seq_rep_monitor_if: stimulus and result bundle of the sequence-repetition
// monitor. The master side drives start/mode/x/y (the SVA lab stimulus);
// the slave side is the monitor, returning pulses and running counters.
interface seq_rep_monitor_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [1:0]       mode;
  logic             x;
  logic             y;
  logic             busy;
  logic             pass_o;
  logic             fail_o;
  logic             timeout_o;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;

  modport master (
    output start, mode, x, y,
    input  busy, pass_o, fail_o, timeout_o, pass_cnt, fail_cnt
  );

  modport slave (
    input  start, mode, x, y,
    output busy, pass_o, fail_o, timeout_o, pass_cnt, fail_cnt
  );
endinterface

// File: rtl/seq_rep_monitor.sv
// seq_rep_monitor: synthesizable evaluation of start |=> (x REP N ##1 y),
// where REP is [*N] (mode 0), [->N] (mode 1) or [=N] (mode 2), chosen per
// attempt. One attempt at a time; starts seen while busy are ignored.
// Verdicts are registered one-cycle pulses plus saturating counters.
//
// Optional feature macro: SEQ_MON_TIMEOUT_EN
//   defined   -> an attempt still unresolved on its TIMEOUT-th evaluation
//                edge fails with timeout_o (strong semantics).
//   undefined -> no timeout logic, timeout_o is 0 and an unresolved
//                attempt stays busy until reset (weak semantics).
module seq_rep_monitor #(
  parameter int N       = 2,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  seq_rep_monitor_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REP    = 2'd1,
    ST_WAIT_Y = 2'd2
  } state_e;

  localparam logic [1:0]       MODE_CONSEC  = 2'd0;
  localparam logic [1:0]       MODE_GOTO    = 2'd1;
  localparam logic [1:0]       MODE_NONCONS = 2'd2;
  localparam logic [3:0]       N_L          = 4'(N);
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_r;
  state_e           state_eval_s;
  state_e           state_nxt_s;
  logic [3:0]       xc_r;
  logic [3:0]       xc_nxt_s;
  logic [3:0]       xc_inc_s;
  logic [1:0]       mode_q_r;
  logic [1:0]       mode_q_nxt_s;
  logic             eval_pass_s;
  logic             eval_fail_s;
  logic             tmo_s;
  logic             pass_s;
  logic             fail_s;

  logic             busy_d_s;
  logic [CNT_W-1:0] pass_cnt_d_s;
  logic [CNT_W-1:0] fail_cnt_d_s;
  logic             busy_r;
  logic             pass_r;
  logic             fail_r;
  logic [CNT_W-1:0] pass_cnt_r;
  logic [CNT_W-1:0] fail_cnt_r;

  assign xc_inc_s = xc_r + 4'd1;

  // Attempt state: FSM state, x occurrence count and mode latched at start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      xc_r     <= 4'd0;
      mode_q_r <= 2'd0;
    end else begin
      state_r  <= state_nxt_s;
      xc_r     <= xc_nxt_s;
      mode_q_r <= mode_q_nxt_s;
    end
  end

  // Next-state evaluation of the property for the current sample of x/y
  always_comb begin
    state_eval_s = state_r;
    xc_nxt_s     = xc_r;
    mode_q_nxt_s = mode_q_r;
    eval_pass_s  = 1'b0;
    eval_fail_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_eval_s = ST_REP;
          xc_nxt_s     = 4'd0;
          mode_q_nxt_s = bus.mode;
        end else begin
          state_eval_s = ST_IDLE;
        end
      end
      ST_REP: begin
        case (mode_q_r)
          MODE_CONSEC: begin
            // Consecutive repetition: every cycle must carry an x
            if (bus.x) begin
              xc_nxt_s = xc_inc_s;
              if (xc_inc_s == N_L) begin
                state_eval_s = ST_WAIT_Y;
              end else begin
                state_eval_s = ST_REP;
              end
            end else begin
              eval_fail_s = 1'b1;
            end
          end
          MODE_GOTO, MODE_NONCONS: begin
            // Gaps between occurrences of x are tolerated
            if (bus.x) begin
              xc_nxt_s = xc_inc_s;
              if (xc_inc_s == N_L) begin
                state_eval_s = ST_WAIT_Y;
              end else begin
                state_eval_s = ST_REP;
              end
            end else begin
              state_eval_s = ST_REP;
            end
          end
          default: begin
            // Reserved repetition kind fails on the first evaluation edge
            eval_fail_s = 1'b1;
          end
        endcase
      end
      ST_WAIT_Y: begin
        case (mode_q_r)
          MODE_CONSEC, MODE_GOTO: begin
            // y must arrive exactly one cycle after the Nth x
            if (bus.y) begin
              eval_pass_s = 1'b1;
            end else begin
              eval_fail_s = 1'b1;
            end
          end
          MODE_NONCONS: begin
            // y may come later, but an extra x before it breaks [=N]
            if (bus.y) begin
              eval_pass_s = 1'b1;
            end else if (bus.x) begin
              eval_fail_s = 1'b1;
            end else begin
              state_eval_s = ST_WAIT_Y;
            end
          end
          default: begin
            eval_fail_s = 1'b1;
          end
        endcase
      end
      default: begin
        state_eval_s = ST_IDLE;
      end
    endcase
  end

`ifdef SEQ_MON_TIMEOUT_EN
  localparam int             CYC_W    = $clog2(TIMEOUT + 1);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(TIMEOUT - 1);
  localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);

  logic [CYC_W-1:0] cyc_r;
  logic             tmo_r;

  // Evaluation-edge counter: 0 on the first edge after start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_r <= {CYC_W{1'b0}};
    end else if (state_r == ST_IDLE) begin
      cyc_r <= {CYC_W{1'b0}};
    end else begin
      cyc_r <= cyc_r + CYC_ONE;
    end
  end

  // A regular verdict on the last allowed edge takes precedence over timeout
  assign tmo_s = (state_r != ST_IDLE) && !eval_pass_s && !eval_fail_s &&
                 (cyc_r == CYC_LAST);

  // Registered timeout pulse, aligned with fail_o
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_r <= 1'b0;
    end else begin
      tmo_r <= tmo_s;
    end
  end

  assign bus.timeout_o = tmo_r;
`else
  logic unused_timeout_s;

  // TIMEOUT only matters when the timeout feature is compiled in
  assign unused_timeout_s = ^TIMEOUT;
  assign tmo_s            = 1'b0;
  assign bus.timeout_o    = 1'b0;
`endif

  assign pass_s      = eval_pass_s;
  assign fail_s      = eval_fail_s | tmo_s;
  assign state_nxt_s = (pass_s || fail_s) ? ST_IDLE : state_eval_s;

  // Output decode: next busy level and saturating counter updates
  always_comb begin
    busy_d_s     = (state_nxt_s != ST_IDLE);
    pass_cnt_d_s = pass_cnt_r;
    fail_cnt_d_s = fail_cnt_r;
    if (pass_s && (pass_cnt_r != CNT_MAX)) begin
      pass_cnt_d_s = pass_cnt_r + CNT_ONE;
    end else begin
      pass_cnt_d_s = pass_cnt_r;
    end
    if (fail_s && (fail_cnt_r != CNT_MAX)) begin
      fail_cnt_d_s = fail_cnt_r + CNT_ONE;
    end else begin
      fail_cnt_d_s = fail_cnt_r;
    end
  end

  // Registered outputs: busy level, verdict pulses and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r     <= 1'b0;
      pass_r     <= 1'b0;
      fail_r     <= 1'b0;
      pass_cnt_r <= {CNT_W{1'b0}};
      fail_cnt_r <= {CNT_W{1'b0}};
    end else begin
      busy_r     <= busy_d_s;
      pass_r     <= pass_s;
      fail_r     <= fail_s;
      pass_cnt_r <= pass_cnt_d_s;
      fail_cnt_r <= fail_cnt_d_s;
    end
  end

  assign bus.busy     = busy_r;
  assign bus.pass_o   = pass_r;
  assign bus.fail_o   = fail_r;
  assign bus.pass_cnt = pass_cnt_r;
  assign bus.fail_cnt = fail_cnt_r;

endmodule

// File: tb/tb_seq_rep_monitor.sv
// tb_seq_rep_monitor: directed scenarios plus randomized traffic for
// seq_rep_monitor. The reference model keeps the raw x/y trace of the
// running attempt and judges it against the repetition rules directly.
module tb_seq_rep_monitor;

  localparam int N       = 2;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 4;
  localparam int CMAX    = (1 << CNT_W) - 1;
  localparam int VW      = 4 + 2 * CNT_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_rep_monitor_if #(.CNT_W(CNT_W)) bus ();

  seq_rep_monitor #(
    .N       (N),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- reference model ----------------
  bit m_busy;
  int m_mode;
  bit xs[$];
  bit ys[$];
  bit m_pass;
  bit m_fail;
  bit m_tmo;
  int m_pcnt;
  int m_fcnt;

  // Judge the trace collected since start: 0 pending, 1 pass, 2 fail, 3 timeout
  function automatic int judge();
    int len;
    int cnt;
    int p;
    int v;
    len = xs.size();
    cnt = 0;
    p   = -1;
    v   = 0;
    for (int i = 0; i < len; i++) begin
      if (xs[i]) begin
        cnt++;
        if (cnt == N && p < 0) p = i;
      end
    end
    case (m_mode)
      0: begin
        for (int i = 0; i < len && i < N; i++) if (!xs[i]) v = 2;
        if (v == 0 && len == N + 1) v = ys[N] ? 1 : 2;
      end
      1: begin
        if (p >= 0 && len == p + 2) v = ys[p + 1] ? 1 : 2;
      end
      2: begin
        if (p >= 0 && len >= p + 2) v = ys[len - 1] ? 1 : (xs[len - 1] ? 2 : 0);
      end
      default: v = 2;
    endcase
`ifdef SEQ_MON_TIMEOUT_EN
    if (v == 0 && len == TIMEOUT) v = 3;
`endif
    return v;
  endfunction

  task automatic model_edge(input bit s, input int md, input bit xx, input bit yy);
    int v;
    m_pass = 1'b0;
    m_fail = 1'b0;
    m_tmo  = 1'b0;
    if (m_busy) begin
      xs.push_back(xx);
      ys.push_back(yy);
      v = judge();
      if (v == 1) begin
        m_pass = 1'b1;
        if (m_pcnt < CMAX) m_pcnt++;
        m_busy = 1'b0;
      end else if (v >= 2) begin
        m_fail = 1'b1;
        m_tmo  = (v == 3);
        if (m_fcnt < CMAX) m_fcnt++;
        m_busy = 1'b0;
      end
    end else if (s) begin
      m_busy = 1'b1;
      m_mode = md;
      xs.delete();
      ys.delete();
    end
  endtask

  function automatic logic [VW-1:0] dut_vec();
    return {bus.busy, bus.pass_o, bus.fail_o, bus.timeout_o, bus.pass_cnt, bus.fail_cnt};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {m_busy, m_pass, m_fail, m_tmo, CNT_W'(m_pcnt), CNT_W'(m_fcnt)};
  endfunction

  function automatic logic [VW-1:0] mk(input bit b, input bit p, input bit f, input bit t,
                                       input int pc, input int fc);
    return {b, p, f, t, CNT_W'(pc), CNT_W'(fc)};
  endfunction

  // ---------------- stimulus ----------------
  task automatic tick(input bit s, input bit [1:0] md, input bit xx, input bit yy);
    bus.start = s;
    bus.mode  = md;
    bus.x     = xx;
    bus.y     = yy;
    @(posedge clk);
    model_edge(s, int'(md), xx, yy);
    #1;
  endtask

  task automatic do_reset();
    bus.start = 1'b0;
    bus.mode  = 2'd0;
    bus.x     = 1'b0;
    bus.y     = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    m_busy = 1'b0;
    m_pass = 1'b0;
    m_fail = 1'b0;
    m_tmo  = 1'b0;
    m_pcnt = 0;
    m_fcnt = 0;
    xs.delete();
    ys.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if (dut_vec() !== mk(0, 0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL reset_state: got %h want %h", dut_vec(), mk(0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_consec_pass();
    do_reset();
    tick(1'b1, 2'd0, 1'b0, 1'b0);
    tick(1'b0, 2'd0, 1'b1, 1'b0);
    tick(1'b0, 2'd0, 1'b1, 1'b0);
    checks++;
    if (dut_vec() !== mk(1, 0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL consec_busy_e3: got %h want %h", dut_vec(), mk(1, 0, 0, 0, 0, 0));
    end
    tick(1'b0, 2'd0, 1'b0, 1'b1);
    checks++;
    if (dut_vec() !== mk(0, 1, 0, 0, 1, 0)) begin
      errors++;
      $display("FAIL consec_pass_e4: got %h want %h", dut_vec(), mk(0, 1, 0, 0, 1, 0));
    end
    tick(1'b0, 2'd0, 1'b0, 1'b0);
    checks++;
    if (dut_vec() !== mk(0, 0, 0, 0, 1, 0)) begin
      errors++;
      $display("FAIL consec_pulse_len: got %h want %h", dut_vec(), mk(0, 0, 0, 0, 1, 0));
    end
  endtask

  task automatic test_consec_extra_x();
    do_reset();
    tick(1'b1, 2'd0, 1'b0, 1'b0);
    tick(1'b0, 2'd0, 1'b1, 1'b0);
    tick(1'b0, 2'd0, 1'b1, 1'b0);
    tick(1'b0, 2'd0, 1'b1, 1'b0);
    checks++;
    if (dut_vec() !== mk(0, 0, 1, 0, 0, 1)) begin
      errors++;
      $display("FAIL consec_extra_x_e4: got %h want %h", dut_vec(), mk(0, 0, 1, 0, 0, 1));
    end
    tick(1'b0, 2'd0, 1'b0, 1'b1);
    checks++;
    if (dut_vec() !== mk(0, 0, 0, 0, 0, 1)) begin
      errors++;
      $display("FAIL consec_extra_x_e5: got %h want %h", dut_vec(), mk(0, 0, 0, 0, 0, 1));
    end
  endtask

  task automatic test_gap_consec_vs_goto();
    do_reset();
    tick(1'b1, 2'd0, 1'b0, 1'b0);
    tick(1'b0, 2'd0, 1'b1, 1'b0);
    tick(1'b0, 2'd0, 1'b0, 1'b0);
    checks++;
    if (dut_vec() !== mk(0, 0, 1, 0, 0, 1)) begin
      errors++;
      $display("FAIL gap_mode0_e3: got %h want %h", dut_vec(), mk(0, 0, 1, 0, 0, 1));
    end
    do_reset();
    tick(1'b1, 2'd1, 1'b0, 1'b0);
    tick(1'b0, 2'd1, 1'b1, 1'b0);
    tick(1'b0, 2'd1, 1'b0, 1'b0);
    tick(1'b0, 2'd1, 1'b1, 1'b0);
    checks++;
    if (dut_vec() !== mk(1, 0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL gap_mode1_e4: got %h want %h", dut_vec(), mk(1, 0, 0, 0, 0, 0));
    end
    tick(1'b0, 2'd1, 1'b0, 1'b1);
    checks++;
    if (dut_vec() !== mk(0, 1, 0, 0, 1, 0)) begin
      errors++;
      $display("FAIL gap_mode1_e5: got %h want %h", dut_vec(), mk(0, 1, 0, 0, 1, 0));
    end
  endtask

  task automatic test_goto_vs_noncons();
    for (int md = 1; md <= 2; md++) begin
      do_reset();
      tick(1'b1, 2'(md), 1'b0, 1'b0);
      tick(1'b0, 2'(md), 1'b1, 1'b0);
      tick(1'b0, 2'(md), 1'b0, 1'b0);
      tick(1'b0, 2'(md), 1'b0, 1'b0);
      tick(1'b0, 2'(md), 1'b1, 1'b0);
      tick(1'b0, 2'(md), 1'b0, 1'b0);
      checks++;
      if (md == 1 && dut_vec() !== mk(0, 0, 1, 0, 0, 1)) begin
        errors++;
        $display("FAIL goto_late_y_e6: got %h want %h", dut_vec(), mk(0, 0, 1, 0, 0, 1));
      end else if (md == 2 && dut_vec() !== mk(1, 0, 0, 0, 0, 0)) begin
        errors++;
        $display("FAIL noncons_wait_e6: got %h want %h", dut_vec(), mk(1, 0, 0, 0, 0, 0));
      end
      tick(1'b0, 2'(md), 1'b0, 1'b1);
      checks++;
      if (md == 1 && dut_vec() !== mk(0, 0, 0, 0, 0, 1)) begin
        errors++;
        $display("FAIL goto_idle_e7: got %h want %h", dut_vec(), mk(0, 0, 0, 0, 0, 1));
      end else if (md == 2 && dut_vec() !== mk(0, 1, 0, 0, 1, 0)) begin
        errors++;
        $display("FAIL noncons_pass_e7: got %h want %h", dut_vec(), mk(0, 1, 0, 0, 1, 0));
      end
    end
  endtask

  task automatic test_timeout();
    logic [VW-1:0] want;
    do_reset();
    tick(1'b1, 2'd2, 1'b0, 1'b0);
    for (int e = 2; e <= 16; e++) tick(1'b0, 2'd2, (e == 2 || e == 5), 1'b0);
    checks++;
    if (dut_vec() !== mk(1, 0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL timeout_e16: got %h want %h", dut_vec(), mk(1, 0, 0, 0, 0, 0));
    end
    tick(1'b0, 2'd2, 1'b0, 1'b0);
`ifdef SEQ_MON_TIMEOUT_EN
    want = mk(0, 0, 1, 1, 0, 1);
`else
    want = mk(1, 0, 0, 0, 0, 0);
`endif
    checks++;
    if (dut_vec() !== want) begin
      errors++;
      $display("FAIL timeout_e17: got %h want %h", dut_vec(), want);
    end
    repeat (13) tick(1'b0, 2'd2, 1'b0, 1'b0);
`ifdef SEQ_MON_TIMEOUT_EN
    want = mk(0, 0, 0, 0, 0, 1);
`else
    want = mk(1, 0, 0, 0, 0, 0);
`endif
    checks++;
    if (dut_vec() !== want) begin
      errors++;
      $display("FAIL timeout_e30: got %h want %h", dut_vec(), want);
    end
  endtask

  task automatic test_mode3();
    do_reset();
    tick(1'b1, 2'd3, 1'b1, 1'b1);
    tick(1'b0, 2'd0, 1'b1, 1'b1);
    checks++;
    if (dut_vec() !== mk(0, 0, 1, 0, 0, 1)) begin
      errors++;
      $display("FAIL mode3_e2: got %h want %h", dut_vec(), mk(0, 0, 1, 0, 0, 1));
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    tick(1'b1, 2'd0, 1'b0, 1'b0);
    tick(1'b1, 2'd3, 1'b1, 1'b0);
    checks++;
    if (dut_vec() !== mk(1, 0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL b2b_second_start_e2: got %h want %h", dut_vec(), mk(1, 0, 0, 0, 0, 0));
    end
    tick(1'b0, 2'd0, 1'b1, 1'b0);
    tick(1'b1, 2'd0, 1'b0, 1'b1);
    checks++;
    if (dut_vec() !== mk(0, 1, 0, 0, 1, 0)) begin
      errors++;
      $display("FAIL b2b_pass_e4: got %h want %h", dut_vec(), mk(0, 1, 0, 0, 1, 0));
    end
    tick(1'b0, 2'd0, 1'b0, 1'b0);
    checks++;
    if (dut_vec() !== mk(0, 0, 0, 0, 1, 0)) begin
      errors++;
      $display("FAIL b2b_verdict_start_ignored: got %h want %h", dut_vec(), mk(0, 0, 0, 0, 1, 0));
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    tick(1'b1, 2'd0, 1'b0, 1'b0);
    tick(1'b0, 2'd0, 1'b1, 1'b0);
    tick(1'b0, 2'd0, 1'b1, 1'b0);
    tick(1'b0, 2'd0, 1'b0, 1'b1);
    tick(1'b1, 2'd1, 1'b0, 1'b0);
    tick(1'b0, 2'd1, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== mk(0, 0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL mid_reset_async: got %h want %h", dut_vec(), mk(0, 0, 0, 0, 0, 0));
    end
    do_reset();
    tick(1'b0, 2'd1, 1'b1, 1'b1);
    checks++;
    if (dut_vec() !== mk(0, 0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL mid_reset_no_pulse: got %h want %h", dut_vec(), mk(0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < CMAX + 3; i++) begin
      tick(1'b1, 2'd0, 1'b0, 1'b0);
      tick(1'b0, 2'd0, 1'b1, 1'b0);
      tick(1'b0, 2'd0, 1'b1, 1'b0);
      tick(1'b0, 2'd0, 1'b0, 1'b1);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL saturation_pass%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (bus.pass_cnt !== CNT_W'(CMAX)) begin
      errors++;
      $display("FAIL saturation_final: got %0d want %0d", bus.pass_cnt, CMAX);
    end
  endtask

  task automatic test_random();
    bit       s;
    bit [1:0] md;
    bit       xx;
    bit       yy;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 249) do_reset();
      s  = ($urandom_range(3) == 0);
      md = ($urandom_range(9) == 0) ? 2'd3 : 2'($urandom_range(2));
      xx = ($urandom_range(2) != 0);
      yy = ($urandom_range(3) == 0);
      tick(s, md, xx, yy);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random_c%0d: got %h want %h", c, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.mode  = 2'd0;
    bus.x     = 1'b0;
    bus.y     = 1'b0;
    test_reset();
    test_consec_pass();
    test_consec_extra_x();
    test_gap_consec_vs_goto();
    test_goto_vs_noncons();
    test_timeout();
    test_mode3();
    test_back_to_back();
    test_mid_reset();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_rep_monitor.md
Name: seq_rep_monitor

Overview:
- RTL sequence-repetition checker that consumes the start/x/y stimulus produced by the SVA lab benches.
- Evaluates the same temporal property in synthesizable logic: start |=> (x REP N ##1 y).
- REP is consecutive [*N], goto [->N] or non-consecutive [=N], selected per attempt.
- Emits registered pass/fail pulses and running counters, so the assertion results can be cross-checked against a hardware model.

Parameters:
- N, 2, repetition count of x; legal range 1..15.
- TIMEOUT, 16, max evaluation cycles per attempt; used only when SEQ_MON_TIMEOUT_EN is defined.
- CNT_W, 16, width of the pass/fail counters.

Ports:
- clk  in  1  clock; all sampling on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  antecedent; sampled each posedge.
- mode  in  2  repetition kind: 0=[*N], 1=[->N], 2=[=N], 3=reserved.
- x  in  1  repeated signal.
- y  in  1  terminating signal.
- busy  out  1  attempt in progress.
- pass_o  out  1  one-cycle pulse: attempt matched.
- fail_o  out  1  one-cycle pulse: attempt failed.
- timeout_o  out  1  one-cycle pulse coincident with fail_o when the failure cause is timeout.
- pass_cnt  out  CNT_W  saturating count of passes.
- fail_cnt  out  CNT_W  saturating count of fails.

Behaviour:
- Reset (async assert, sync release) sets every output to 0, the state to IDLE and all internal counters to 0.
- States:
  - IDLE: waiting for start.
  - REP: counting x occurrences; xc counts 0..N.
  - WAIT_Y: N occurrences of x seen; y now required or permitted.
- IDLE: start=1 at edge k latches mode into mode_q and goes to REP with xc=0. busy=1 from after edge k.
- Evaluation begins at edge k+1 (non-overlapping implication). A start seen while busy is ignored. No pipelining of attempts.
- mode=3 at start: immediate fail at edge k+1, then return to IDLE.
- REP, mode_q=0 (consecutive):
  - x=1: xc++; on reaching N go to WAIT_Y.
  - x=0: fail.
- REP, mode_q=1 or 2: x=1 increments xc; on reaching N go to WAIT_Y. x=0 keeps waiting.
- WAIT_Y, mode_q 0 or 1:
  - Only the single edge after the Nth x is evaluated.
  - y=1: pass. y=0: fail.
- WAIT_Y, mode_q 2:
  - y=1: pass. Pass has priority over a simultaneous x.
  - else x=1: fail (an (N+1)th x).
  - else remain in WAIT_Y.
- Verdict sampled at edge m:
  - pass_o or fail_o is high for exactly the cycle following edge m.
  - State returns to IDLE at edge m and busy drops at the same time.
  - A start sampled at edge m itself is ignored.
- Counters increment on the verdict edge and saturate at all-ones.
- Reset mid-attempt aborts the attempt silently: no pulse, counters cleared.

Optional Feature:
- Macro SEQ_MON_TIMEOUT_EN.
- Defined:
  - A cycle counter runs from edge k+1.
  - If no verdict is reached by the TIMEOUT-th evaluation edge, fail_o and timeout_o pulse and the monitor returns to IDLE. This gives strong-property semantics.
- Undefined:
  - No timeout logic. timeout_o is tied 0.
  - An unresolved attempt stays busy indefinitely (weak semantics); only reset clears it.

Test Plan:
- N=2, mode 0. start at edge1; x=1 at edges 2,3; y=1 at edge 4 -> pass_o after edge 4, pass_cnt=1.
- N=2, mode 0. start at edge1; x=1 at edges 2,3,4; y=1 at edge 5 -> fail_o after edge 4 (y=0 there), fail_cnt=1.
- N=2, x=1 at edges 2,4 (low at 3), y=1 at edge 5:
  - mode 0 -> fail after edge 3.
  - rerun with mode 1 -> pass after edge 5.
- N=2, x=1 at edges 2,5, y=1 at edge 7:
  - mode 1 -> fail after edge 6.
  - mode 2 -> pass after edge 7.
- N=2, mode 2, x=1 at edges 2,5, y never, SEQ_MON_TIMEOUT_EN with TIMEOUT=16 -> fail_o and timeout_o after edge 17.
  - Without the macro: busy remains 1 and no pulse occurs.
- Back-to-back and reset cases:
  - start at edge 1 and again at edge 2 -> the second start is ignored.
  - rst_n low at edge 3 -> busy=0 immediately, no pulse, counters 0.
